// File: rtl/game_core_if.sv
// Button-code input and game-state outputs of game_core.
// The game core is the slave; whatever drives the buttons and reads the state is the master.
interface game_core_if;
   logic [2:0] switch_out;
   logic [1:0] state;
   logic [3:0] player_x;
   logic [3:0] player_y;
   logic [3:0] target_x;
   logic [3:0] target_y;
   logic [7:0] score;
   logic [5:0] time_left;
   logic       hit;

   modport master (
      output switch_out,
      input  state, player_x, player_y, target_x, target_y, score, time_left, hit
   );

   modport slave (
      input  switch_out,
      output state, player_x, player_y, target_x, target_y, score, time_left, hit
   );
endinterface

// File: rtl/game_core.sv
// Grid "catch the target" game: cursor movement from button codes, LFSR target,
// saturating score, per-second countdown and IDLE/PLAY/OVER control.
module game_core #(
   parameter int GRID_W       = 16,
   parameter int GRID_H       = 12,
   parameter int TICK_CYCLES  = 125000000,
   parameter int GAME_SECONDS = 30
) (
   input logic        clk,
   input logic        rst_n,
   game_core_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam int              TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [3:0]      X_MAX     = 4'(GRID_W - 1);
   localparam logic [3:0]      Y_MAX     = 4'(GRID_H - 1);
   localparam logic [3:0]      X_MID     = 4'(GRID_W / 2);
   localparam logic [3:0]      Y_MID     = 4'(GRID_H / 2);
   localparam logic [3:0]      X_SPAN    = 4'(GRID_W);
   localparam logic [3:0]      Y_SPAN    = 4'(GRID_H);
   localparam logic [4:0]      X_SPAN5   = 5'(GRID_W);
   localparam logic [4:0]      Y_SPAN5   = 5'(GRID_H);
   localparam logic [5:0]      SECS      = 6'(GAME_SECONDS);
   localparam logic [15:0]     LFSR_SEED = 16'hACE1;

   state_t        state_q, state_d;
   logic [3:0]    px_q, px_d;
   logic [3:0]    py_q, py_d;
   logic [3:0]    tx_q, tx_d;
   logic [3:0]    ty_q, ty_d;
   logic [7:0]    score_q, score_d;
   logic [5:0]    time_q, time_d;
   logic          hit_q, hit_d;
   logic [2:0]    sw_prev_q, sw_prev_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [15:0]   lfsr_q, lfsr_d;

   logic       evt;
   logic [3:0] move_x, move_y;
   logic [3:0] avoid_x, avoid_y;
   logic [3:0] nt_x, nt_y;
   logic       on_target;

   // A code counts once, on the cycle it first appears; 0 and 5..7 never count.
   always_comb begin
      evt = (bus.switch_out >= 3'd1) && (bus.switch_out <= 3'd4)
            && (bus.switch_out != sw_prev_q);
   end

   always_comb begin
      move_x = px_q;
      move_y = py_q;
      if (evt) begin
         case (bus.switch_out)
            3'd1: if (py_q != 4'd0)  move_y = py_q - 4'd1;
            3'd2: if (py_q != Y_MAX) move_y = py_q + 4'd1;
            3'd3: if (px_q != 4'd0)  move_x = px_q - 4'd1;
            3'd4: if (px_q != X_MAX) move_x = px_q + 4'd1;
            default: ;
         endcase
      end
   end

   // A fresh target must not sit on the cell the player occupies after this edge.
   always_comb begin
      avoid_x = (state_q == S_IDLE) ? X_MID : move_x;
      avoid_y = (state_q == S_IDLE) ? Y_MID : move_y;

      nt_x = lfsr_q[3:0];
      if ({1'b0, lfsr_q[3:0]} >= X_SPAN5) nt_x = lfsr_q[3:0] - X_SPAN;
      nt_y = lfsr_q[11:8];
      if ({1'b0, lfsr_q[11:8]} >= Y_SPAN5) nt_y = lfsr_q[11:8] - Y_SPAN;

      if ((nt_x == avoid_x) && (nt_y == avoid_y)) begin
         nt_x = (nt_x == X_MAX) ? 4'd0 : nt_x + 4'd1;
      end
   end

   always_comb begin
      on_target = (px_q == tx_q) && (py_q == ty_q);
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      sw_prev_d = bus.switch_out;
   end

   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      score_d = score_q;
      time_d  = time_q;
      tick_d  = tick_q;
      hit_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (evt) begin
               state_d = S_PLAY;
               px_d    = X_MID;
               py_d    = Y_MID;
               score_d = 8'd0;
               time_d  = SECS;
               tick_d  = '0;
               tx_d    = nt_x;
               ty_d    = nt_y;
            end
         end

         S_PLAY: begin
            px_d = move_x;
            py_d = move_y;
            if (on_target) begin
               score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
               hit_d   = 1'b1;
               tx_d    = nt_x;
               ty_d    = nt_y;
            end
            // Expiry and a capture can land on the same edge; both are kept.
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               time_d = time_q - 6'd1;
               if (time_q == 6'd1) state_d = S_OVER;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end

         S_OVER: begin
            tick_d = '0;
            if (evt) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         px_q      <= X_MID;
         py_q      <= Y_MID;
         tx_q      <= 4'd0;
         ty_q      <= 4'd0;
         score_q   <= 8'd0;
         time_q    <= SECS;
         hit_q     <= 1'b0;
         sw_prev_q <= 3'd0;
         tick_q    <= '0;
         lfsr_q    <= LFSR_SEED;
      end else begin
         state_q   <= state_d;
         px_q      <= px_d;
         py_q      <= py_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         score_q   <= score_d;
         time_q    <= time_d;
         hit_q     <= hit_d;
         sw_prev_q <= sw_prev_d;
         tick_q    <= tick_d;
         lfsr_q    <= lfsr_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.player_x  = px_q;
   assign bus.player_y  = py_q;
   assign bus.target_x  = tx_q;
   assign bus.target_y  = ty_q;
   assign bus.score     = score_q;
   assign bus.time_left = time_q;
   assign bus.hit       = hit_q;

endmodule
